// File: rtl/nec_ir_rx.sv
// NEC infrared receiver: 9 ms/4.5 ms leader, 32 LSB-first bits (addr, cmd, ~cmd), 560 us stop.
// Define NEC_REPEAT_EN to compile in repeat-code decoding (RPT_STOP state and rpt_flag).
module nec_ir_rx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TOL_PCT    = 25,
  parameter int unsigned TIMEOUT_US = 12000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iIR,
  output logic [15:0] iraddr,
  output logic [7:0]  ircmd,
  output logic        get_flag,
  output logic        err_flag,
  output logic        rpt_flag,
  output logic        busy
);

  localparam int unsigned PreDiv = CLK_HZ / 1000000;
  localparam int unsigned PreW   = (PreDiv > 1) ? $clog2(PreDiv) : 1;
  localparam int unsigned CntW   = $clog2(TIMEOUT_US + 1);
  localparam logic [PreW-1:0] PreMax = PreW'(PreDiv - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_US);

  function automatic logic [CntW-1:0] lim(input int unsigned nom, input int unsigned pct);
    return CntW'(nom * pct / 100);
  endfunction

  function automatic logic in_win(input logic [CntW-1:0] w, input logic [CntW-1:0] lo,
                                  input logic [CntW-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  localparam logic [CntW-1:0] LeadLowLo  = lim(9000, 100 - TOL_PCT);
  localparam logic [CntW-1:0] LeadLowHi  = lim(9000, 100 + TOL_PCT);
  localparam logic [CntW-1:0] LeadHighLo = lim(4500, 100 - TOL_PCT);
  localparam logic [CntW-1:0] LeadHighHi = lim(4500, 100 + TOL_PCT);
  localparam logic [CntW-1:0] ShortLo    = lim(560, 100 - TOL_PCT);
  localparam logic [CntW-1:0] ShortHi    = lim(560, 100 + TOL_PCT);
  localparam logic [CntW-1:0] OneLo      = lim(1690, 100 - TOL_PCT);
  localparam logic [CntW-1:0] OneHi      = lim(1690, 100 + TOL_PCT);
`ifdef NEC_REPEAT_EN
  localparam logic [CntW-1:0] RptHighLo  = lim(2250, 100 - TOL_PCT);
  localparam logic [CntW-1:0] RptHighHi  = lim(2250, 100 + TOL_PCT);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLeadLow,
    StLeadHigh,
    StBitLow,
    StBitHigh,
    StStop
`ifdef NEC_REPEAT_EN
    , StRptStop
`endif
  } state_e;

  state_e state_q, state_d;

  // Input synchroniser and edge detect; all flops idle high so reset release is edge-free.
  logic ir_s1, ir_s2, ir_prev;
  logic fall, rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_s1   <= 1'b1;
      ir_s2   <= 1'b1;
      ir_prev <= 1'b1;
    end else begin
      ir_s1   <= iIR;
      ir_s2   <= ir_s1;
      ir_prev <= ir_s2;
    end
  end

  assign fall = ir_prev & ~ir_s2;
  assign rise = ~ir_prev & ir_s2;

  // 1 us prescaler and saturating phase-width counter, both restarted on every edge.
  logic [PreW-1:0] pre_q;
  logic [CntW-1:0] width_q;
  logic            timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      width_q <= '0;
    end else if (fall || rise) begin
      pre_q   <= '0;
      width_q <= '0;
    end else if (pre_q == PreMax) begin
      pre_q <= '0;
      if (width_q != CntMax) width_q <= width_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign timeout = (width_q == CntMax);

  logic win_lead_low, win_lead_high, win_short, win_one;
  assign win_lead_low  = in_win(width_q, LeadLowLo, LeadLowHi);
  assign win_lead_high = in_win(width_q, LeadHighLo, LeadHighHi);
  assign win_short     = in_win(width_q, ShortLo, ShortHi);
  assign win_one       = in_win(width_q, OneLo, OneHi);
`ifdef NEC_REPEAT_EN
  logic win_rpt_high;
  assign win_rpt_high  = in_win(width_q, RptHighLo, RptHighHi);
`endif

  logic [5:0]  bit_cnt_q;
  logic [31:0] shift_q;
  logic        cmd_ok;
  assign cmd_ok = ((shift_q[23:16] ^ shift_q[31:24]) == 8'hFF);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; a timeout always takes priority over a coincident edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (fall) state_d = StLeadLow;
      end
      StLeadLow: begin
        if (timeout)   state_d = StIdle;
        else if (rise) state_d = win_lead_low ? StLeadHigh : StIdle;
      end
      StLeadHigh: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (fall) begin
          if (win_lead_high) state_d = StBitLow;
`ifdef NEC_REPEAT_EN
          else if (win_rpt_high) state_d = StRptStop;
`endif
          else state_d = StIdle;
        end
      end
      StBitLow: begin
        if (timeout)   state_d = StIdle;
        else if (rise) state_d = win_short ? StBitHigh : StIdle;
      end
      StBitHigh: begin
        if (timeout) begin
          state_d = StIdle;
        end else if (fall) begin
          if (win_short || win_one) state_d = (bit_cnt_q == 6'd31) ? StStop : StBitLow;
          else                      state_d = StIdle;
        end
      end
      StStop: begin
        if (timeout || rise) state_d = StIdle;
      end
`ifdef NEC_REPEAT_EN
      StRptStop: begin
        if (timeout || rise) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef NEC_REPEAT_EN
  logic have_frame_q;
  logic rpt_d, rpt_q;
`endif
  logic get_d, err_d, get_q, err_q;
  logic shift_en, shift_bit, cnt_clr;

  // Output / datapath-control logic
  always_comb begin
    get_d     = 1'b0;
    err_d     = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    cnt_clr   = 1'b0;
`ifdef NEC_REPEAT_EN
    rpt_d     = 1'b0;
`endif
    case (state_q)
      StLeadHigh: begin
        if (timeout) begin
          err_d = 1'b1;
        end else if (fall) begin
          if (win_lead_high) cnt_clr = 1'b1;
`ifdef NEC_REPEAT_EN
          else if (!win_rpt_high) err_d = 1'b1;
`else
          else err_d = 1'b1;
`endif
        end
      end
      StBitLow: begin
        if (timeout || (rise && !win_short)) err_d = 1'b1;
      end
      StBitHigh: begin
        if (timeout) begin
          err_d = 1'b1;
        end else if (fall) begin
          if (win_short || win_one) begin
            shift_en  = 1'b1;
            shift_bit = win_one;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStop: begin
        if (timeout) begin
          err_d = 1'b1;
        end else if (rise) begin
          if (win_short && cmd_ok) get_d = 1'b1;
          else                     err_d = 1'b1;
        end
      end
`ifdef NEC_REPEAT_EN
      StRptStop: begin
        if (timeout) begin
          err_d = 1'b1;
        end else if (rise) begin
          if (win_short && have_frame_q) rpt_d = 1'b1;
          else                           err_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      iraddr    <= '0;
      ircmd     <= '0;
      get_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      get_q <= get_d;
      err_q <= err_d;
      if (cnt_clr) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        shift_q   <= {shift_bit, shift_q[31:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (get_d) begin
        iraddr <= shift_q[15:0];
        ircmd  <= shift_q[23:16];
      end
    end
  end

`ifdef NEC_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_frame_q <= 1'b0;
      rpt_q        <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      if (get_d) have_frame_q <= 1'b1;
    end
  end
  assign rpt_flag = rpt_q;
`else
  assign rpt_flag = 1'b0;
`endif

  assign get_flag = get_q;
  assign err_flag = err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_nec_ir_rx.sv
// Scoreboard bench for nec_ir_rx at 1 MHz (one width tick per clock); honours NEC_REPEAT_EN.
`timescale 1ns/1ps
module tb_nec_ir_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir = 1'b1;
  logic [15:0] iraddr;
  logic [7:0]  ircmd;
  logic        get_flag, err_flag, rpt_flag, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } exp_t;

  localparam logic [2:0] KGet = 3'b100;
  localparam logic [2:0] KErr = 3'b010;
  localparam logic [2:0] KRpt = 3'b001;

  exp_t exp_q[$];

  nec_ir_rx #(
    .CLK_HZ    (1000000),
    .TOL_PCT   (25),
    .TIMEOUT_US(12000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iIR     (ir),
    .iraddr  (iraddr),
    .ircmd   (ircmd),
    .get_flag(get_flag),
    .err_flag(err_flag),
    .rpt_flag(rpt_flag),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (get_flag || err_flag || rpt_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got {get,err,rpt}=%b expected none",
                 {get_flag, err_flag, rpt_flag});
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {29'b0, get_flag, err_flag, rpt_flag}, {29'b0, e.kind});
        check("iraddr_at_strobe", {16'b0, iraddr}, {16'b0, e.addr});
        check("ircmd_at_strobe", {24'b0, ircmd}, {24'b0, e.cmd});
      end
    end
  end

  task automatic phase(input logic lvl, input int us);
    ir = lvl;
    repeat (us) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    phase(1'b0, 9000);
    phase(1'b1, 4500);
    for (int i = 0; i < nbits; i++) begin
      phase(1'b0, 560);
      phase(1'b1, w[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] c, input logic [7:0] nc);
    send_bits({nc, c, a}, 32);
    phase(1'b0, 560);
    phase(1'b1, 200);
  endtask

  task automatic send_repeat();
    phase(1'b0, 9000);
    phase(1'b1, 2250);
    phase(1'b0, 560);
    phase(1'b1, 200);
  endtask

  initial begin
    rst_n = 1'b0;
    ir    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_iraddr", {16'b0, iraddr}, 32'h0);
    check("rst_ircmd", {24'b0, ircmd}, 32'h0);
    check("rst_strobes", {29'b0, get_flag, err_flag, rpt_flag}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_after_release", {31'b0, busy}, 32'h0);

    // Repeat code with no prior good frame is an error in either build.
    exp_q.push_back('{KErr, 16'h0000, 8'h00});
    send_repeat();

    // 5000 us leader low: silently abandoned.
    phase(1'b0, 5000);
    check("busy_in_short_leader", {31'b0, busy}, 32'h1);
    phase(1'b1, 50);
    check("busy_after_short_leader", {31'b0, busy}, 32'h0);

    exp_q.push_back('{KGet, 16'h00FF, 8'h45});
    send_frame(16'h00FF, 8'h45, 8'hBA);
    check("hold_iraddr", {16'b0, iraddr}, 32'h00FF);
    check("hold_ircmd", {24'b0, ircmd}, 32'h45);

    exp_q.push_back('{KErr, 16'h00FF, 8'h45});
    send_frame(16'h00FF, 8'h45, 8'hBB);

    // Reset in the middle of bit 13's low phase.
    send_bits({8'hBA, 8'h45, 16'h00FF}, 12);
    ir = 1'b0;
    repeat (100) @(negedge clk);
    check("busy_mid_frame", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    ir    = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_iraddr", {16'b0, iraddr}, 32'h0);
    check("midrst_ircmd", {24'b0, ircmd}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_strobes", {29'b0, get_flag, err_flag, rpt_flag}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_after_midrst", {31'b0, busy}, 32'h0);

    // LSB-first ordering: address bit 0 and command bit 7 set.
    exp_q.push_back('{KGet, 16'h0001, 8'h80});
    send_frame(16'h0001, 8'h80, 8'h7F);

`ifdef NEC_REPEAT_EN
    exp_q.push_back('{KRpt, 16'h0001, 8'h80});
    send_repeat();
`endif

    repeat (50) @(negedge clk);
    check("final_iraddr", {16'b0, iraddr}, 32'h0001);
    check("final_ircmd", {24'b0, ircmd}, 32'h80);
    check("all_expected_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
